// File: rtl/reorder_buffer.sv
// Reorder buffer: circular queue of in-flight instructions that retires
// results to the commit stage strictly in program order.
// Optional feature: define ROB_FLUSH_EN to add the flush input port.
module reorder_buffer #(
  parameter int unsigned ROB_DEPTH = 16,
  parameter int unsigned TAG_W     = $clog2(ROB_DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
`ifdef ROB_FLUSH_EN
  input  logic             flush,
`endif
  input  logic             dispatch_valid,
  input  logic [4:0]       dispatch_dest_reg,
  input  logic [1:0]       dispatch_mem_size,
  output logic             dispatch_ready,
  output logic [TAG_W-1:0] dispatch_tag,
  input  logic             complete_valid,
  input  logic [TAG_W-1:0] complete_tag,
  input  logic [63:0]      complete_value,
  input  logic [63:0]      complete_addr,
  output logic             head_valid,
  output logic             head_ready,
  output logic [63:0]      head_value,
  output logic [63:0]      head_dest_addr,
  output logic [4:0]       head_dest_reg,
  output logic [1:0]       head_mem_size,
  output logic [TAG_W:0]   rob_count
);

  localparam logic [TAG_W:0]   FULL_COUNT = (TAG_W+1)'(ROB_DEPTH);
  localparam logic [TAG_W-1:0] LAST_IDX   = TAG_W'(ROB_DEPTH - 1);

  // Per-entry state
  logic        r_valid    [ROB_DEPTH];
  logic        r_ready    [ROB_DEPTH];
  logic [63:0] r_value    [ROB_DEPTH];
  logic [63:0] r_addr     [ROB_DEPTH];
  logic [4:0]  r_dest_reg [ROB_DEPTH];
  logic [1:0]  r_mem_size [ROB_DEPTH];

  logic [TAG_W-1:0] r_head;
  logic [TAG_W-1:0] r_tail;
  logic [TAG_W:0]   r_count;

  logic             w_nonempty;
  logic             w_alloc;
  logic             w_retire;
  logic             w_complete;
  logic [TAG_W-1:0] w_head_next;
  logic [TAG_W-1:0] w_tail_next;

  // Handshake decode and pointer wrap from registered state only
  always_comb begin
    w_nonempty  = (r_count != '0);
    w_alloc     = dispatch_valid && (r_count != FULL_COUNT);
    w_retire    = w_nonempty && r_ready[r_head];
    w_complete  = complete_valid && r_valid[complete_tag];
    w_head_next = (r_head == LAST_IDX) ? '0 : r_head + 1'b1;
    w_tail_next = (r_tail == LAST_IDX) ? '0 : r_tail + 1'b1;
  end

  // Head fields are forced to zero while empty so the reset view is all-zero
  always_comb begin
    dispatch_ready = (r_count != FULL_COUNT);
    dispatch_tag   = r_tail;
    rob_count      = r_count;
    head_valid     = w_nonempty;
    head_ready     = w_retire;
    head_value     = w_nonempty ? r_value[r_head]    : '0;
    head_dest_addr = w_nonempty ? r_addr[r_head]     : '0;
    head_dest_reg  = w_nonempty ? r_dest_reg[r_head] : '0;
    head_mem_size  = w_nonempty ? r_mem_size[r_head] : '0;
  end

  // Entry and pointer updates; reset, then flush, dominate everything else.
  // Statement order gives dispatch the last word on a shared index.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned i = 0; i < ROB_DEPTH; i++) begin
        r_valid[i] <= 1'b0;
        r_ready[i] <= 1'b0;
      end
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end
`ifdef ROB_FLUSH_EN
    else if (flush) begin
      for (int unsigned i = 0; i < ROB_DEPTH; i++) begin
        r_valid[i] <= 1'b0;
        r_ready[i] <= 1'b0;
      end
      r_tail  <= r_head;
      r_count <= '0;
    end
`endif
    else begin
      if (w_complete) begin
        r_value[complete_tag] <= complete_value;
        r_addr[complete_tag]  <= complete_addr;
        r_ready[complete_tag] <= 1'b1;
      end
      if (w_retire) begin
        r_valid[r_head] <= 1'b0;
        r_ready[r_head] <= 1'b0;
        r_head          <= w_head_next;
      end
      if (w_alloc) begin
        r_valid[r_tail]    <= 1'b1;
        r_ready[r_tail]    <= 1'b0;
        r_dest_reg[r_tail] <= dispatch_dest_reg;
        r_mem_size[r_tail] <= dispatch_mem_size;
        r_value[r_tail]    <= '0;
        r_addr[r_tail]     <= '0;
        r_tail             <= w_tail_next;
      end
      unique case ({w_alloc, w_retire})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed self-checking bench for reorder_buffer (default depth 16).
module tb_reorder_buffer;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned TW    = 4;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
`ifdef ROB_FLUSH_EN
  logic          flush = 1'b0;
`endif
  logic          dispatch_valid = 1'b0;
  logic [4:0]    dispatch_dest_reg = '0;
  logic [1:0]    dispatch_mem_size = '0;
  logic          dispatch_ready;
  logic [TW-1:0] dispatch_tag;
  logic          complete_valid = 1'b0;
  logic [TW-1:0] complete_tag = '0;
  logic [63:0]   complete_value = '0;
  logic [63:0]   complete_addr = '0;
  logic          head_valid;
  logic          head_ready;
  logic [63:0]   head_value;
  logic [63:0]   head_dest_addr;
  logic [4:0]    head_dest_reg;
  logic [1:0]    head_mem_size;
  logic [TW:0]   rob_count;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clock = ~clock;

  reorder_buffer #(.ROB_DEPTH(DEPTH), .TAG_W(TW)) dut (
    .clock            (clock),
    .reset            (reset),
`ifdef ROB_FLUSH_EN
    .flush            (flush),
`endif
    .dispatch_valid   (dispatch_valid),
    .dispatch_dest_reg(dispatch_dest_reg),
    .dispatch_mem_size(dispatch_mem_size),
    .dispatch_ready   (dispatch_ready),
    .dispatch_tag     (dispatch_tag),
    .complete_valid   (complete_valid),
    .complete_tag     (complete_tag),
    .complete_value   (complete_value),
    .complete_addr    (complete_addr),
    .head_valid       (head_valid),
    .head_ready       (head_ready),
    .head_value       (head_value),
    .head_dest_addr   (head_dest_addr),
    .head_dest_reg    (head_dest_reg),
    .head_mem_size    (head_mem_size),
    .rob_count        (rob_count)
  );

  // Advance one clock; inputs are driven and outputs observed 1 ns after the edge
  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset;
    dispatch_valid = 1'b0;
    complete_valid = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset;
    do_reset();
    if (dispatch_ready !== 1'b1) begin n_bad++; $display("FAIL rst_dready got %b want 1", dispatch_ready); end
    n_cmp++;
    if (dispatch_tag !== 4'd0) begin n_bad++; $display("FAIL rst_dtag got %0d want 0", dispatch_tag); end
    n_cmp++;
    if (head_ready !== 1'b0) begin n_bad++; $display("FAIL rst_hready got %b want 0", head_ready); end
    n_cmp++;
    if (head_value !== 64'd0) begin n_bad++; $display("FAIL rst_hvalue got %h want 0", head_value); end
    n_cmp++;
    if (head_dest_addr !== 64'd0) begin n_bad++; $display("FAIL rst_haddr got %h want 0", head_dest_addr); end
    n_cmp++;
    if (head_dest_reg !== 5'd0) begin n_bad++; $display("FAIL rst_hdest got %0d want 0", head_dest_reg); end
    n_cmp++;
    if (head_mem_size !== 2'd0) begin n_bad++; $display("FAIL rst_hsize got %0d want 0", head_mem_size); end
    n_cmp++;
    for (int i = 0; i < 10; i++) begin
      if (head_valid !== 1'b0 || dispatch_ready !== 1'b1 || rob_count !== 5'd0) begin
        n_bad++;
        $display("FAIL idle cyc=%0d got hv=%b dr=%b cnt=%0d want hv=0 dr=1 cnt=0",
                 i, head_valid, dispatch_ready, rob_count);
      end
      n_cmp++;
      tick();
    end
  endtask

  task automatic test_single;
    do_reset();
    dispatch_valid = 1'b1; dispatch_dest_reg = 5'd3; dispatch_mem_size = 2'd0;
    if (dispatch_tag !== 4'd0) begin n_bad++; $display("FAIL single_tag got %0d want 0", dispatch_tag); end
    n_cmp++;
    tick();
    dispatch_valid = 1'b0;
    if (head_valid !== 1'b1 || head_ready !== 1'b0 || rob_count !== 5'd1) begin
      n_bad++; $display("FAIL single_alloc got hv=%b hr=%b cnt=%0d want 1 0 1", head_valid, head_ready, rob_count);
    end
    n_cmp++;
    complete_valid = 1'b1; complete_tag = 4'd0; complete_value = 64'h55; complete_addr = 64'd0;
    tick();
    complete_valid = 1'b0;
    if (head_valid !== 1'b1 || head_ready !== 1'b1) begin
      n_bad++; $display("FAIL single_ready got hv=%b hr=%b want 1 1", head_valid, head_ready);
    end
    n_cmp++;
    if (head_value !== 64'h55 || head_dest_reg !== 5'd3) begin
      n_bad++; $display("FAIL single_fields got val=%h dest=%0d want 55 3", head_value, head_dest_reg);
    end
    n_cmp++;
    tick();
    if (rob_count !== 5'd0 || head_valid !== 1'b0) begin
      n_bad++; $display("FAIL single_retire got cnt=%0d hv=%b want 0 0", rob_count, head_valid);
    end
    n_cmp++;
  endtask

  task automatic test_out_of_order;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      dispatch_valid = 1'b1; dispatch_dest_reg = 5'(10 + i);
      tick();
    end
    dispatch_valid = 1'b0;
    for (int t = 2; t >= 1; t--) begin
      complete_valid = 1'b1; complete_tag = TW'(t); complete_value = 64'h100 + 64'(t);
      tick();
      if (head_ready !== 1'b0 || rob_count !== 5'd3) begin
        n_bad++; $display("FAIL ooo_wait tag=%0d got hr=%b cnt=%0d want 0 3", t, head_ready, rob_count);
      end
      n_cmp++;
    end
    complete_valid = 1'b1; complete_tag = 4'd0; complete_value = 64'h100;
    tick();
    complete_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (head_ready !== 1'b1 || head_dest_reg !== 5'(10 + k) || head_value !== 64'h100 + 64'(k)
          || rob_count !== 5'(3 - k)) begin
        n_bad++;
        $display("FAIL ooo_order k=%0d got hr=%b dest=%0d val=%h cnt=%0d want 1 %0d %h %0d",
                 k, head_ready, head_dest_reg, head_value, rob_count, 10 + k, 64'h100 + 64'(k), 3 - k);
      end
      n_cmp++;
      tick();
    end
    if (rob_count !== 5'd0) begin n_bad++; $display("FAIL ooo_empty got %0d want 0", rob_count); end
    n_cmp++;
  endtask

  task automatic test_full_wrap;
    do_reset();
    for (int i = 0; i < 16; i++) begin
      dispatch_valid = 1'b1; dispatch_dest_reg = 5'(i);
      if (dispatch_tag !== TW'(i)) begin n_bad++; $display("FAIL fill_tag got %0d want %0d", dispatch_tag, i); end
      n_cmp++;
      tick();
    end
    if (dispatch_ready !== 1'b0 || rob_count !== 5'd16) begin
      n_bad++; $display("FAIL full got dr=%b cnt=%0d want 0 16", dispatch_ready, rob_count);
    end
    n_cmp++;
    dispatch_dest_reg = 5'd20;
    tick();
    if (rob_count !== 5'd16 || head_dest_reg !== 5'd0) begin
      n_bad++; $display("FAIL full_ignore got cnt=%0d dest=%0d want 16 0", rob_count, head_dest_reg);
    end
    n_cmp++;
    complete_valid = 1'b1; complete_tag = 4'd0; complete_value = 64'h9;
    tick();
    complete_valid = 1'b0;
    if (head_ready !== 1'b1 || dispatch_ready !== 1'b0) begin
      n_bad++; $display("FAIL full_headrdy got hr=%b dr=%b want 1 0", head_ready, dispatch_ready);
    end
    n_cmp++;
    tick();
    if (rob_count !== 5'd15 || dispatch_ready !== 1'b1 || dispatch_tag !== 4'd0 || head_dest_reg !== 5'd1) begin
      n_bad++; $display("FAIL full_retire got cnt=%0d dr=%b tag=%0d dest=%0d want 15 1 0 1",
                        rob_count, dispatch_ready, dispatch_tag, head_dest_reg);
    end
    n_cmp++;
    dispatch_dest_reg = 5'd25;
    tick();
    dispatch_valid = 1'b0;
    if (rob_count !== 5'd16 || dispatch_ready !== 1'b0 || dispatch_tag !== 4'd1) begin
      n_bad++; $display("FAIL wrap_alloc got cnt=%0d dr=%b tag=%0d want 16 0 1", rob_count, dispatch_ready, dispatch_tag);
    end
    n_cmp++;
  endtask

  task automatic test_store;
    do_reset();
    dispatch_valid = 1'b1; dispatch_dest_reg = 5'd31; dispatch_mem_size = 2'd2;
    complete_valid = 1'b1; complete_tag = 4'd0; complete_value = 64'hDEAD;
    tick();
    dispatch_valid = 1'b0; dispatch_mem_size = 2'd0;
    complete_valid = 1'b0;
    if (head_ready !== 1'b0 || head_value !== 64'd0) begin
      n_bad++; $display("FAIL same_idx got hr=%b val=%h want 0 0", head_ready, head_value);
    end
    n_cmp++;
    complete_valid = 1'b1; complete_tag = 4'd0; complete_value = 64'hAB; complete_addr = 64'h1000;
    tick();
    complete_valid = 1'b0;
    if (head_dest_addr !== 64'h1000 || head_mem_size !== 2'd2 || head_dest_reg !== 5'd31 || head_value !== 64'hAB) begin
      n_bad++; $display("FAIL store got addr=%h size=%0d dest=%0d val=%h want 1000 2 31 ab",
                        head_dest_addr, head_mem_size, head_dest_reg, head_value);
    end
    n_cmp++;
    dispatch_valid = 1'b1; dispatch_dest_reg = 5'd7;
    tick();
    dispatch_valid = 1'b0;
    if (rob_count !== 5'd1 || head_dest_reg !== 5'd7 || head_ready !== 1'b0 || head_dest_addr !== 64'd0) begin
      n_bad++; $display("FAIL alloc_retire got cnt=%0d dest=%0d hr=%b addr=%h want 1 7 0 0",
                        rob_count, head_dest_reg, head_ready, head_dest_addr);
    end
    n_cmp++;
  endtask

  task automatic test_reset_mid;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      dispatch_valid = 1'b1; dispatch_dest_reg = 5'(i);
      tick();
    end
    reset = 1'b1; dispatch_valid = 1'b1;
    complete_valid = 1'b1; complete_tag = 4'd0;
    tick();
    reset = 1'b0; dispatch_valid = 1'b0; complete_valid = 1'b0;
    if (rob_count !== 5'd0 || head_valid !== 1'b0 || dispatch_tag !== 4'd0) begin
      n_bad++; $display("FAIL reset_mid got cnt=%0d hv=%b tag=%0d want 0 0 0", rob_count, head_valid, dispatch_tag);
    end
    n_cmp++;
  endtask

`ifdef ROB_FLUSH_EN
  task automatic test_flush;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      dispatch_valid = 1'b1; dispatch_dest_reg = 5'(i);
      tick();
    end
    flush = 1'b1;
    tick();
    flush = 1'b0; dispatch_valid = 1'b0;
    if (rob_count !== 5'd0 || head_valid !== 1'b0 || dispatch_tag !== 4'd0) begin
      n_bad++; $display("FAIL flush got cnt=%0d hv=%b tag=%0d want 0 0 0", rob_count, head_valid, dispatch_tag);
    end
    n_cmp++;
  endtask
`endif

  initial begin
    tick();
    test_reset();
    test_single();
    test_out_of_order();
    test_full_wrap();
    test_store();
    test_reset_mid();
`ifdef ROB_FLUSH_EN
    test_flush();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
